// File: rtl/register_block.sv
// Control/status register file: ID, CTRL, sticky W1C event STATUS, IRQ enable,
// scratch and a free-running compare timer, with a registered read port.
module register_block #(
    parameter int          ADDR_W   = 3,
    parameter int          N_EVT    = 4,
    parameter logic [31:0] ID_VALUE = 32'h5045_0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W:0]   addr,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    input  logic [N_EVT-1:0]  evt_i,
    output logic [7:0]        ctrl_o,
    output logic              irq_o
);

    logic [7:0]     ctrl_reg,    ctrl_next;
    logic [N_EVT:0] status_reg,  status_next;
    logic [N_EVT:0] irq_en_reg,  irq_en_next;
    logic [31:0]    scratch_reg, scratch_next;
    logic [31:0]    tmr_cnt_reg, tmr_cnt_next;
    logic [31:0]    tmr_cmp_reg, tmr_cmp_next;
    logic [31:0]    rd_data;
    logic [N_EVT:0] w1c_mask;
    logic           tmr_match;
    logic           irq_next;

    // One write-select per mapped writable word; ID (word 0) is read-only.
    logic [6:1] wr_sel;
    genvar gi;
    generate
        for (gi = 1; gi <= 6; gi++) begin : g_dec
            assign wr_sel[gi] = wr && (32'(addr) == gi);
        end
    endgenerate

    // A bus write to the counter pre-empts both the increment and the match.
    assign tmr_match = ctrl_reg[0] && (tmr_cnt_reg == tmr_cmp_reg) && !wr_sel[5];
    assign w1c_mask  = wr_sel[2] ? data_i[N_EVT:0] : '0;

    // Event set has priority over a simultaneous W1C of the same bit.
    generate
        for (gi = 0; gi < N_EVT; gi++) begin : g_status
            assign status_next[gi] = (status_reg[gi] & ~w1c_mask[gi]) | evt_i[gi];
        end
    endgenerate
    assign status_next[N_EVT] = (status_reg[N_EVT] & ~w1c_mask[N_EVT]) | tmr_match;

    always_comb begin
        ctrl_next    = wr_sel[1] ? data_i[7:0]       : ctrl_reg;
        irq_en_next  = wr_sel[3] ? data_i[N_EVT:0]   : irq_en_reg;
        scratch_next = wr_sel[4] ? data_i            : scratch_reg;
        tmr_cmp_next = wr_sel[6] ? data_i            : tmr_cmp_reg;
        tmr_cnt_next = tmr_cnt_reg;
        if (wr_sel[5]) begin
            tmr_cnt_next = data_i;
        end else if (tmr_match) begin
            tmr_cnt_next = '0;
        end else if (ctrl_reg[0]) begin
            tmr_cnt_next = tmr_cnt_reg + 32'd1;
        end
        irq_next = |(status_next & irq_en_next);
    end

    // Read mux uses current register values, so a same-cycle write is not seen.
    always_comb begin
        rd_data = '0;
        case (32'(addr))
            0:       rd_data = ID_VALUE;
            1:       rd_data = {24'd0, ctrl_reg};
            2:       rd_data = 32'(status_reg);
            3:       rd_data = 32'(irq_en_reg);
            4:       rd_data = scratch_reg;
            5:       rd_data = tmr_cnt_reg;
            6:       rd_data = tmr_cmp_reg;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_reg    <= '0;
            status_reg  <= '0;
            irq_en_reg  <= '0;
            scratch_reg <= '0;
            tmr_cnt_reg <= '0;
            tmr_cmp_reg <= 32'hFFFF_FFFF;
            data_o      <= '0;
            irq_o       <= 1'b0;
        end else begin
            ctrl_reg    <= ctrl_next;
            status_reg  <= status_next;
            irq_en_reg  <= irq_en_next;
            scratch_reg <= scratch_next;
            tmr_cnt_reg <= tmr_cnt_next;
            tmr_cmp_reg <= tmr_cmp_next;
            irq_o       <= irq_next;
            if (rd) begin
                data_o <= rd_data;
            end
        end
    end

    assign ctrl_o = ctrl_reg;

endmodule

// File: tb/tb_register_block.sv
// Directed bench for register_block: register map, W1C events, IRQ, timer and reset.
module tb_register_block;

    localparam int ADDR_W = 3;
    localparam int N_EVT  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr = 1'b0;
    logic              rd = 1'b0;
    logic [ADDR_W:0]   addr = '0;
    logic [31:0]       data_i = '0;
    logic [31:0]       data_o;
    logic [N_EVT-1:0]  evt_i = '0;
    logic [7:0]        ctrl_o;
    logic              irq_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] cnt_exp [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

    register_block #(.ADDR_W(ADDR_W), .N_EVT(N_EVT), .ID_VALUE(32'h5045_0001)) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .rd     (rd),
        .addr   (addr),
        .data_i (data_i),
        .data_o (data_o),
        .evt_i  (evt_i),
        .ctrl_o (ctrl_o),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [ADDR_W:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; data_i = d;
        step();
        wr = 1'b0;
    endtask

    task automatic do_rd(input string tag, input logic [ADDR_W:0] a, input logic [31:0] exp);
        rd = 1'b1; addr = a;
        step();
        rd = 1'b0;
        check(tag, data_o, exp);
    endtask

    initial begin
        // Reset state
        step(); step();
        check("rst_data_o", data_o, 32'h0);
        check("rst_irq", {31'd0, irq_o}, 32'h0);
        check("rst_ctrl_o", {24'd0, ctrl_o}, 32'h0);
        reset = 1'b0;

        do_rd("rd_id", 0, 32'h5045_0001);
        do_rd("rd_ctrl_rst", 1, 32'h0);
        do_rd("rd_cnt_rst", 5, 32'h0);
        do_rd("rd_cmp_rst", 6, 32'hFFFF_FFFF);
        step();
        check("data_o_hold", data_o, 32'hFFFF_FFFF);
        check("irq_idle", {31'd0, irq_o}, 32'h0);

        // Scratch and unmapped
        do_wr(4, 32'hA5A5_5A5A);
        do_rd("rd_scratch", 4, 32'hA5A5_5A5A);
        do_wr(9, 32'h0000_1234);
        do_rd("rd_unmapped9", 9, 32'h0);
        do_wr(7, 32'h0000_5555);
        do_rd("rd_unmapped7", 7, 32'h0);
        do_rd("scratch_kept", 4, 32'hA5A5_5A5A);

        // Back-to-back reads
        rd = 1'b1; addr = 0;
        step();
        check("b2b_id", data_o, 32'h5045_0001);
        addr = 4;
        step();
        check("b2b_scratch", data_o, 32'hA5A5_5A5A);
        rd = 1'b0;

        // Implemented-bit masks
        do_wr(1, 32'hABCD_EF12);
        check("ctrl_o_mask", {24'd0, ctrl_o}, 32'h12);
        do_rd("rd_ctrl_mask", 1, 32'h12);
        do_wr(3, 32'hFFFF_FFFF);
        do_rd("rd_irqen_mask", 3, 32'h1F);
        do_wr(3, 32'h4);
        do_wr(1, 32'h0);

        // Events, IRQ, W1C
        evt_i = 4'h4;
        step();
        evt_i = 4'h0;
        check("irq_evt2", {31'd0, irq_o}, 32'h1);
        do_rd("status_evt2", 2, 32'h4);
        do_wr(2, 32'h4);
        check("irq_cleared", {31'd0, irq_o}, 32'h0);
        do_rd("status_clr", 2, 32'h0);
        evt_i = 4'h4; wr = 1'b1; addr = 2; data_i = 32'h4;
        step();
        evt_i = 4'h0; wr = 1'b0;
        check("irq_set_wins", {31'd0, irq_o}, 32'h1);
        do_rd("status_set_win", 2, 32'h4);
        do_wr(2, 32'hFFFF_FFFF);
        check("irq_clr_all", {31'd0, irq_o}, 32'h0);
        evt_i = 4'h2;
        step();
        evt_i = 4'h0;
        check("irq_masked", {31'd0, irq_o}, 32'h0);
        do_rd("status_evt1", 2, 32'h2);
        do_wr(2, 32'h2);

        // Timer period CMP=3
        do_wr(6, 32'd3);
        do_wr(1, 32'h1);
        check("ctrl_o_run", {24'd0, ctrl_o}, 32'h1);
        rd = 1'b1; addr = 5;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("tmr_cnt_%0d", i), data_o, cnt_exp[i]);
        end
        rd = 1'b0;
        do_rd("status_match", 2, 32'h10);

        // Bus write to TMR_CNT on the match cycle
        do_wr(1, 32'h0);
        do_wr(5, 32'h0);
        do_wr(2, 32'hFF);
        do_wr(1, 32'h1);
        step(); step(); step();
        do_wr(5, 32'd10);
        do_rd("cnt_wr_wins", 5, 32'd10);
        do_rd("no_match_on_wr", 2, 32'h0);

        // CMP=0 matches every cycle; match beats W1C
        do_wr(1, 32'h0);
        do_wr(5, 32'h0);
        do_wr(2, 32'hFF);
        do_wr(6, 32'h0);
        do_wr(1, 32'h1);
        do_wr(2, 32'h10);
        do_rd("cmp0_set_wins", 2, 32'h10);
        do_rd("cmp0_cnt", 5, 32'h0);

        // Frozen timer never matches
        do_wr(1, 32'h0);
        do_wr(6, 32'd7);
        do_wr(5, 32'd7);
        do_wr(2, 32'hFF);
        step(); step();
        do_rd("frozen_cnt", 5, 32'd7);
        do_rd("frozen_nomatch", 2, 32'h0);

        // rd+wr same cycle to CTRL
        rd = 1'b1; wr = 1'b1; addr = 1; data_i = 32'h3;
        step();
        rd = 1'b0; wr = 1'b0;
        check("rdwr_old", data_o, 32'h0);
        check("rdwr_ctrl_o", {24'd0, ctrl_o}, 32'h3);
        do_rd("rdwr_new", 1, 32'h3);

        // Async reset mid-access
        do_wr(3, 32'h1F);
        evt_i = 4'h1;
        step();
        evt_i = 4'h0;
        check("irq_pre_rst", {31'd0, irq_o}, 32'h1);
        wr = 1'b1; addr = 4; data_i = 32'hDEAD_BEEF;
        #2 reset = 1'b1;
        #1;
        check("arst_ctrl_o", {24'd0, ctrl_o}, 32'h0);
        check("arst_irq", {31'd0, irq_o}, 32'h0);
        check("arst_data_o", data_o, 32'h0);
        step();
        wr = 1'b0;
        reset = 1'b0;
        do_rd("post_scratch", 4, 32'h0);
        do_rd("post_cnt", 5, 32'h0);
        do_rd("post_cmp", 6, 32'hFFFF_FFFF);
        do_rd("post_irqen", 3, 32'h0);
        do_rd("post_status", 2, 32'h0);
        do_rd("post_ctrl", 1, 32'h0);
        check("post_irq", {31'd0, irq_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
